vga_grid_controller: RTL



---
 rtl/vga_grid_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/vga_grid_controller.sv
// Parameterised VGA timing generator that paints a GRID_ROWS x GRID_COLS grid of flat-colour cells.
// Optional cell cursor outline is enabled by defining VGA_GRID_CURSOR_EN.
module vga_grid_controller #(
    parameter int H_VIS     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VIS     = 400,
    parameter int V_FP      = 12,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 35,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b1,
    parameter int GRID_COLS = 3,
    parameter int GRID_ROWS = 3,
    parameter int CW        = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              pix_en,
    input  logic [GRID_ROWS*GRID_COLS*CW-1:0] cell_r,
    input  logic [GRID_ROWS*GRID_COLS*CW-1:0] cell_g,
    input  logic [GRID_ROWS*GRID_COLS*CW-1:0] cell_b,
`ifdef VGA_GRID_CURSOR_EN
    input  logic [3:0]                        cursor_row,
    input  logic [3:0]                        cursor_col,
    input  logic                              cursor_on,
`endif
    output logic [CW-1:0]                     r,
    output logic [CW-1:0]                     g,
    output logic [CW-1:0]                     b,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              active,
    output logic                              frame_start,
    output logic [$clog2(H_VIS+H_FP+H_SYNC+H_BP)-1:0] h_cnt,
    output logic [$clog2(V_VIS+V_FP+V_SYNC+V_BP)-1:0] v_cnt
);
    localparam int HT     = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW     = $clog2(HT);
    localparam int VW     = $clog2(VT);
    localparam int CELL_W = H_VIS / GRID_COLS;
    localparam int CELL_H = V_VIS / GRID_ROWS;
    localparam int CXW    = $clog2(CELL_W + 1);
    localparam int CYW    = $clog2(CELL_H + 1);

    logic [HW-1:0]  h_q, h_d;
    logic [VW-1:0]  v_q, v_d;
    logic [CXW-1:0] cx_q, cx_d;
    logic [CYW-1:0] cy_q, cy_d;
    logic [4:0]     col_q, col_d, row_q, row_d;
    logic [CW-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
    logic           hs_q, hs_d, vs_q, vs_d, act_q, act_d, fs_q, fs_d;
    logic           h_end, v_end, vis, in_grid, in_hs, in_vs;
    int             k;
`ifdef VGA_GRID_CURSOR_EN
    logic [3:0]     cur_row_q, cur_col_q;
    logic           cur_on_q, border;
`endif

    always_comb begin
        h_end   = (h_q == HW'(HT - 1));
        v_end   = (v_q == VW'(VT - 1));
        vis     = (h_q < HW'(H_VIS)) && (v_q < VW'(V_VIS));
        in_grid = (col_q < 5'(GRID_COLS)) && (row_q < 5'(GRID_ROWS));
        in_hs   = (h_q >= HW'(H_VIS + H_FP)) && (h_q < HW'(H_VIS + H_FP + H_SYNC));
        in_vs   = (v_q >= VW'(V_VIS + V_FP)) && (v_q < VW'(V_VIS + V_FP + V_SYNC));
        k       = in_grid ? int'(row_q) * GRID_COLS + int'(col_q) : 0;
`ifdef VGA_GRID_CURSOR_EN
        // Two-pixel outline hugging the inside of the selected cell.
        border  = cur_on_q && (row_q == {1'b0, cur_row_q}) && (col_q == {1'b0, cur_col_q}) &&
                  (int'(cx_q) < 2 || int'(cx_q) >= CELL_W - 2 ||
                   int'(cy_q) < 2 || int'(cy_q) >= CELL_H - 2);
`endif
        h_d   = h_q;   v_d   = v_q;
        cx_d  = cx_q;  cy_d  = cy_q;
        col_d = col_q; row_d = row_q;
        r_d   = r_q;   g_d   = g_q;   b_d = b_q;
        hs_d  = hs_q;  vs_d  = vs_q;  act_d = act_q;
        fs_d  = 1'b0;
        if (pix_en) begin
            if (h_end) begin
                h_d   = '0;
                cx_d  = '0;
                col_d = '0;
                if (v_end) begin
                    v_d   = '0;
                    cy_d  = '0;
                    row_d = '0;
                    fs_d  = 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                    // Row index saturates at GRID_ROWS so leftover lines read as remainder.
                    if (row_q < 5'(GRID_ROWS)) begin
                        if (cy_q == CYW'(CELL_H - 1)) begin
                            cy_d  = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            cy_d = cy_q + 1'b1;
                        end
                    end
                end
            end else begin
                h_d = h_q + 1'b1;
                if (col_q < 5'(GRID_COLS)) begin
                    if (cx_q == CXW'(CELL_W - 1)) begin
                        cx_d  = '0;
                        col_d = col_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            act_d = vis;
            hs_d  = in_hs ? HS_POL : ~HS_POL;
            vs_d  = in_vs ? VS_POL : ~VS_POL;
            if (vis && in_grid) begin
                r_d = cell_r[k*CW +: CW];
                g_d = cell_g[k*CW +: CW];
                b_d = cell_b[k*CW +: CW];
`ifdef VGA_GRID_CURSOR_EN
                if (border) begin
                    r_d = '1;
                    g_d = '1;
                    b_d = '1;
                end
`endif
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_q   <= '0;   v_q   <= '0;
            cx_q  <= '0;   cy_q  <= '0;
            col_q <= '0;   row_q <= '0;
            r_q   <= '0;   g_q   <= '0;   b_q <= '0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            act_q <= 1'b0;
            fs_q  <= 1'b0;
        end else begin
            h_q   <= h_d;   v_q   <= v_d;
            cx_q  <= cx_d;  cy_q  <= cy_d;
            col_q <= col_d; row_q <= row_d;
            r_q   <= r_d;   g_q   <= g_d;   b_q <= b_d;
            hs_q  <= hs_d;  vs_q  <= vs_d;
            act_q <= act_d;
            fs_q  <= fs_d;
        end
    end

`ifdef VGA_GRID_CURSOR_EN
    // Cursor is latched on the same edge the counters wrap, so it never moves mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_row_q <= '0;
            cur_col_q <= '0;
            cur_on_q  <= 1'b0;
        end else if (fs_d) begin
            cur_row_q <= cursor_row;
            cur_col_q <= cursor_col;
            cur_on_q  <= cursor_on;
        end
    end
`endif

    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign active      = act_q;
    assign frame_start = fs_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
endmodule
